// File: rtl/ram_burst_master.sv
// ram_burst_master: valid/ready burst controller for a single-port synchronous RAM; optional full-RAM clear under RAM_BURST_MASTER_CLEAR_EN
module ram_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef RAM_BURST_MASTER_CLEAR_EN
  input  logic                  clr_start,
  output logic                  clr_busy,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  typedef enum logic [2:0] {
    IDLE, WR, RD_ISSUE, RD_WAIT, RD_OUT
`ifdef RAM_BURST_MASTER_CLEAR_EN
    , CLR
`endif
  } state_t;
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic                    done_q, done_d;
  logic                    last_beat;
  assign last_beat = beat_cnt_q == len_q;
  assign ram_addr  = cur_addr_q;
  assign wr_ready  = (state_q == WR) && !rst;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign done      = done_q;
`ifdef RAM_BURST_MASTER_CLEAR_EN
  assign clr_busy  = state_q == CLR;
  assign req_ready = (state_q == IDLE) && !rst && !clr_start;
  assign ram_we    = !rst && (((state_q == WR) && write_q && wr_valid) || (state_q == CLR));
  assign ram_din   = (state_q == CLR) ? '0 : wr_data;
`else
  assign req_ready = (state_q == IDLE) && !rst;
  assign ram_we    = !rst && (state_q == WR) && write_q && wr_valid;
  assign ram_din   = wr_data;
`endif
  // next-state and register updates for the burst sequencer
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    write_d    = write_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef RAM_BURST_MASTER_CLEAR_EN
        if (clr_start) begin
          state_d    = CLR;
          cur_addr_d = '0;
        end else
`endif
        if (req_valid) begin
          cur_addr_d = req_addr;
          len_d      = req_len;
          beat_cnt_d = '0;
          write_d    = req_write;
          state_d    = req_write ? WR : RD_ISSUE;
        end
      end
      WR: begin
        if (wr_valid) begin
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          beat_cnt_d = beat_cnt_q + ADDR_WIDTH'(1);
          state_d    = last_beat ? IDLE : WR;
          done_d     = last_beat;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        rd_data_d  = ram_dout;
        rd_valid_d = 1'b1;
        rd_last_d  = last_beat;
        state_d    = RD_OUT;
      end
      RD_OUT: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          done_d     = rd_last_q;
          state_d    = rd_last_q ? IDLE : RD_ISSUE;
          cur_addr_d = rd_last_q ? cur_addr_q : cur_addr_q + ADDR_WIDTH'(1);
          beat_cnt_d = rd_last_q ? beat_cnt_q : beat_cnt_q + ADDR_WIDTH'(1);
        end
      end
`ifdef RAM_BURST_MASTER_CLEAR_EN
      CLR: begin
        cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
        state_d    = (&cur_addr_q) ? IDLE : CLR;
        done_d     = &cur_addr_q;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      write_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      write_q    <= write_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: directed self-checking bench with an attached RAM model
module tb_ram_burst_master;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [3:0] req_addr, req_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [7:0] rd_data;
  logic       done, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] mem [16];
  int         errors = 0;
  int         checks = 0;
`ifdef RAM_BURST_MASTER_CLEAR_EN
  logic       clr_start, clr_busy;
`endif

  always #5 clk = ~clk;

  ram_burst_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
`ifdef RAM_BURST_MASTER_CLEAR_EN
    .clr_start(clr_start), .clr_busy(clr_busy),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // single-port RAM model: read-first, one-cycle registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic write_burst(input logic [3:0] a, input logic [3:0] l, input logic [127:0] d);
    logic [3:0] ea;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = l;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_req_ready: got %b want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 4'(i);
      wr_valid = 1'b1; wr_data = d[8*i +: 8];
      #1;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== ea || wr_ready !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL wr_beat%0d: we=%b addr=%h wr_ready=%b done=%b want 1/%h/1/0", i, ram_we, ram_addr, wr_ready, done, ea);
      end
      @(negedge clk);
    end
    wr_valid = 1'b1; wr_data = 8'hFF;
    #1;
    checks++;
    if (done !== 1'b1 || ram_we !== 1'b0 || wr_ready !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL wr_done: done=%b we=%b wr_ready=%b req_ready=%b want 1/0/0/1", done, ram_we, wr_ready, req_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse: done=%b want 0", done); end
  endtask

  task automatic read_burst(input logic [3:0] a, input logic [3:0] l, input logic [127:0] d, input int stall_beat, input int stall_n);
    logic [3:0] ea;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = l; rd_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_req_ready: got %b want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 4'(i);
      #1;
      checks++;
      if (ram_addr !== ea || rd_valid !== 1'b0 || ram_we !== 1'b0) begin
        errors++; $display("FAIL rd_issue%0d: addr=%h rd_valid=%b we=%b want %h/0/0", i, ram_addr, rd_valid, ram_we, ea);
      end
      @(negedge clk);
      @(negedge clk);
      if (i == stall_beat) begin
        rd_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          #1;
          checks++;
          if (rd_valid !== 1'b1 || rd_data !== d[8*i +: 8] || ram_addr !== ea) begin
            errors++; $display("FAIL rd_stall%0d: valid=%b data=%h addr=%h want 1/%h/%h", k, rd_valid, rd_data, ram_addr, d[8*i +: 8], ea);
          end
          @(negedge clk);
        end
        rd_ready = 1'b1;
      end
      #1;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== d[8*i +: 8] || rd_last !== (i == int'(l))) begin
        errors++; $display("FAIL rd_beat%0d: valid=%b data=%h last=%b want 1/%h/%b", i, rd_valid, rd_data, rd_last, d[8*i +: 8], i == int'(l));
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (done !== 1'b1 || rd_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rd_done: done=%b rd_valid=%b req_ready=%b want 1/0/1", done, rd_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 4'h0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || rd_last !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL reset: req_ready=%b we=%b addr=%h rd_valid=%b rd_data=%h last=%b done=%b wr_ready=%b", req_ready, ram_we, ram_addr, rd_valid, rd_data, rd_last, done, wr_ready);
    end
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release: req_ready=%b want 1", req_ready); end
  endtask

  task automatic test_write();
    write_burst(4'h3, 4'h3, 128'hA3A2A1A0);
    checks++;
    if (mem[3] !== 8'hA0 || mem[4] !== 8'hA1 || mem[5] !== 8'hA2 || mem[6] !== 8'hA3 || mem[7] !== 8'h5A || mem[2] !== 8'h5A) begin
      errors++; $display("FAIL write_mem: %h %h %h %h %h %h want 5A A0 A1 A2 A3 5A", mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]);
    end
  endtask

  task automatic test_read();
    read_burst(4'h3, 4'h3, 128'hA3A2A1A0, 99, 0);
  endtask

  task automatic test_wrap();
    write_burst(4'hE, 4'h3, 128'h44332211);
    checks++;
    if (mem[14] !== 8'h11 || mem[15] !== 8'h22 || mem[0] !== 8'h33 || mem[1] !== 8'h44 || mem[2] !== 8'h5A) begin
      errors++; $display("FAIL wrap_mem: %h %h %h %h %h want 11 22 33 44 5A", mem[14], mem[15], mem[0], mem[1], mem[2]);
    end
    read_burst(4'hE, 4'h3, 128'h44332211, 99, 0);
  endtask

  task automatic test_backpressure();
    read_burst(4'h3, 4'h3, 128'hA3A2A1A0, 1, 5);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h8; req_len = 4'h3;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = 8'hC0 + 8'(i);
      @(negedge clk);
    end
    rst = 1'b1; wr_data = 8'hC2;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (ram_we !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0) begin
        errors++; $display("FAIL rst_mid%0d: we=%b done=%b req_ready=%b want 0/0/0", k, ram_we, done, req_ready);
      end
      @(negedge clk);
    end
    rst = 1'b0; wr_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0 || ram_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: req_ready=%b done=%b we=%b want 1/0/0", req_ready, done, ram_we);
    end
    checks++;
    if (mem[8] !== 8'hC0 || mem[9] !== 8'hC1 || mem[10] !== 8'h5A || mem[11] !== 8'h5A) begin
      errors++; $display("FAIL rst_mid_mem: %h %h %h %h want C0 C1 5A 5A", mem[8], mem[9], mem[10], mem[11]);
    end
  endtask

`ifdef RAM_BURST_MASTER_CLEAR_EN
  task automatic test_clear();
    @(negedge clk);
    clr_start = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h5; req_len = 4'h0;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL clr_req_ready: got %b want 0", req_ready); end
    @(negedge clk);
    clr_start = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (clr_busy !== 1'b1 || ram_we !== 1'b1 || ram_din !== 8'h00 || ram_addr !== 4'(i) || req_ready !== 1'b0) begin
        errors++; $display("FAIL clr_cycle%0d: busy=%b we=%b din=%h addr=%h req_ready=%b", i, clr_busy, ram_we, ram_din, ram_addr, req_ready);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (clr_busy !== 1'b0 || done !== 1'b1 || req_ready !== 1'b1) begin
      errors++; $display("FAIL clr_end: busy=%b done=%b req_ready=%b want 0/1/1", clr_busy, done, req_ready);
    end
    read_burst(4'h0, 4'hF, 128'h0, 99, 0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h5A;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_len = 4'h0;
    wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b1;
`ifdef RAM_BURST_MASTER_CLEAR_EN
    clr_start = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_backpressure();
    test_reset_mid_burst();
`ifdef RAM_BURST_MASTER_CLEAR_EN
    test_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
